// File: rtl/encrypter_pipe_if.sv
// Producer/consumer handshake bundle for encrypter_pipe: word-in with valid/ready, ciphertext-out with pop.
interface encrypter_pipe_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  localparam int ROT_W = $clog2(WIDTH);
  localparam int FW    = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] data_in_p;
  logic [ROT_W-1:0] key_rotation_p;
  logic             prog_p;
  logic             data_ready_in_p;
  logic             ready_p;
  logic [WIDTH-1:0] data_out_c;
  logic             data_ready_out_c;
  logic             capture_c;
  logic [FW-1:0]    fill_level_c;

  modport master (
    output data_in_p, key_rotation_p, prog_p, data_ready_in_p, capture_c,
    input  ready_p, data_out_c, data_ready_out_c, fill_level_c
  );

  modport slave (
    input  data_in_p, key_rotation_p, prog_p, data_ready_in_p, capture_c,
    output ready_p, data_out_c, data_ready_out_c, fill_level_c
  );
endinterface

// File: rtl/encrypter_pipe.sv
// XOR-with-rotated-key encrypter: stage reg + DEPTH FIFO, 2-cycle input-to-output latency, ready_p from registered fill only.
// Optional macro ENCRYPTER_AUTO_ROTATE_EN adds a per-word rotation offset that clears on key load.
module encrypter_pipe #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input logic            clk,
  input logic            reset,
  encrypter_pipe_if.slave bus
);
  localparam int ROT_W = $clog2(WIDTH);
  localparam int AW    = $clog2(DEPTH);
  localparam int FW    = AW + 1;

  logic [WIDTH-1:0] key_q;
  logic [WIDTH-1:0] stage_q;
  logic             stage_vld_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [FW-1:0]    cnt_q;
  logic [FW-1:0]    fill;
  logic [ROT_W-1:0] offset;
  logic [ROT_W-1:0] rot;
  logic [ROT_W-1:0] idx;
  logic [WIDTH-1:0] key_rot;
  logic             accept;
  logic             acc_key;
  logic             acc_enc;
  logic             fifo_nonempty;
  logic             pop;

  // The stage register always drains into the FIFO, so the combined count gates acceptance.
  assign fill          = cnt_q + FW'(stage_vld_q);
  assign bus.ready_p   = (fill < FW'(DEPTH));
  assign accept        = bus.data_ready_in_p & bus.ready_p;
  assign acc_key       = accept & bus.prog_p;
  assign acc_enc       = accept & ~bus.prog_p;
  assign fifo_nonempty = (cnt_q != '0);
  assign pop           = bus.capture_c & fifo_nonempty;

  assign rot = bus.key_rotation_p + offset;

  always_comb begin
    key_rot = '0;
    idx     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      idx        = ROT_W'(i) - rot;
      key_rot[i] = key_q[idx];
    end
  end

`ifdef ENCRYPTER_AUTO_ROTATE_EN
  logic [ROT_W-1:0] offset_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      offset_q <= '0;
    end else if (acc_key) begin
      offset_q <= '0;
    end else if (acc_enc) begin
      offset_q <= offset_q + ROT_W'(1);
    end
  end

  assign offset = offset_q;
`else
  assign offset = '0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_q       <= '0;
      stage_q     <= '0;
      stage_vld_q <= 1'b0;
    end else begin
      stage_vld_q <= acc_enc;
      if (acc_key) begin
        key_q <= bus.data_in_p;
      end
      if (acc_enc) begin
        stage_q <= bus.data_in_p ^ key_rot;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (stage_vld_q) begin
      mem_q[wr_ptr_q] <= stage_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (stage_vld_q) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      cnt_q <= cnt_q + FW'(stage_vld_q) - FW'(pop);
    end
  end

  // Storage is not reset, so the head is masked while the FIFO is empty.
  assign bus.data_ready_out_c = fifo_nonempty;
  assign bus.data_out_c       = fifo_nonempty ? mem_q[rd_ptr_q] : '0;
  assign bus.fill_level_c     = fill;
endmodule

// File: tb/tb_encrypter_pipe.sv
// Self-checking bench for encrypter_pipe: directed vector table, corner sequences, and randomized traffic vs a queue model.
module tb_encrypter_pipe;
  localparam int W = 32;
  localparam int D = 4;

  logic clk;
  logic reset;

  encrypter_pipe_if #(.WIDTH(W), .DEPTH(D)) bus ();

  encrypter_pipe #(.WIDTH(W), .DEPTH(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    int          vis;
  } ent_t;

  typedef struct {
    logic [31:0] key;
    logic [31:0] pt;
    int          rot;
    logic [31:0] exp;
  } vec_t;

  ent_t        q[$];
  int          cyc;
  logic [31:0] m_key;
  int          m_off;
  int          nvec;
  int          nfail;

  function automatic logic [31:0] rotl(logic [31:0] k, int r);
    if (r == 0) return k;
    return (k << r) | (k >> (32 - r));
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outputs();
    bit head_vis;
    head_vis = (q.size() > 0) && (q[0].vis <= cyc);
    chk("ready_p", 64'(bus.ready_p), 64'(q.size() < D));
    chk("data_ready_out_c", 64'(bus.data_ready_out_c), 64'(head_vis));
    chk("fill_level_c", 64'(bus.fill_level_c), 64'(q.size()));
    chk("data_out_c", 64'(bus.data_out_c), head_vis ? 64'(q[0].word) : 64'd0);
  endtask

  task automatic model_reset();
    q.delete();
    m_key = '0;
    m_off = 0;
  endtask

  // One clock edge: the model consumes the same inputs the DUT sees, then outputs are compared.
  task automatic step();
    bit   acc;
    bit   pop;
    int   sz;
    ent_t e;
    @(posedge clk);
    sz  = q.size();
    acc = bus.data_ready_in_p && (sz < D);
    pop = bus.capture_c && (sz > 0) && (q[0].vis <= cyc);
    cyc++;
    if (pop) void'(q.pop_front());
    if (acc) begin
      if (bus.prog_p) begin
        m_key = bus.data_in_p;
        m_off = 0;
      end else begin
        e.word = bus.data_in_p ^ rotl(m_key, (int'(bus.key_rotation_p) + m_off) % W);
        e.vis  = cyc + 1;
        q.push_back(e);
`ifdef ENCRYPTER_AUTO_ROTATE_EN
        m_off = (m_off + 1) % W;
`endif
      end
    end
    #1;
    check_outputs();
  endtask

  task automatic drive(bit vld, bit prog, logic [31:0] din, int rot, bit cap);
    bus.data_ready_in_p = vld;
    bus.prog_p          = prog;
    bus.data_in_p       = din;
    bus.key_rotation_p  = 5'(rot);
    bus.capture_c       = cap;
  endtask

  vec_t vt[7];

  initial begin
    nvec  = 0;
    nfail = 0;
    cyc   = 0;
    model_reset();

    vt[0] = '{32'hB4352B93, 32'h1F537C8A, 0,  32'hAB665719};
    vt[1] = '{32'hB4352B93, 32'h1F537C8A, 4,  32'h5C01C5B1};
    vt[2] = '{32'hB4352B93, 32'h1F537C8A, 1,  32'h77392BAD};
    vt[3] = '{32'h00000000, 32'h12345678, 7,  32'h12345678};
    vt[4] = '{32'hFFFFFFFF, 32'h00000000, 31, 32'hFFFFFFFF};
    vt[5] = '{32'h80000000, 32'h00000000, 31, 32'h40000000};
    vt[6] = '{32'h00000001, 32'h00000000, 31, 32'h80000000};

    reset = 1'b0;
    drive(0, 0, '0, 0, 1);
    #23;
    check_outputs();
    reset = 1'b1;
    step();

    // Directed vectors; the key is reloaded each time so any rotation offset starts from zero.
    for (int i = 0; i < 7; i++) begin
      drive(1, 1, vt[i].key, 0, 0);
      step();
      drive(1, 0, vt[i].pt, vt[i].rot, 0);
      step();
      if (i == 0) chk("latency_after_accept", 64'(bus.data_ready_out_c), 64'd0);
      drive(0, 0, '0, 0, 0);
      step();
      if (i == 0) chk("latency_visible", 64'(bus.data_ready_out_c), 64'd1);
      chk("vec_out", 64'(bus.data_out_c), 64'(vt[i].exp));
      drive(0, 0, '0, 0, 1);
      step();
      drive(0, 0, '0, 0, 0);
    end

    // Same plaintext twice after one key load.
    drive(1, 1, 32'hB4352B93, 0, 0);
    step();
    drive(1, 0, 32'h1F537C8A, 0, 0);
    step();
    step();
    drive(0, 0, '0, 0, 0);
    step();
    chk("twice_first", 64'(bus.data_out_c), 64'h00000000AB665719);
    drive(0, 0, '0, 0, 1);
    step();
`ifdef ENCRYPTER_AUTO_ROTATE_EN
    chk("twice_second", 64'(bus.data_out_c), 64'(32'h1F537C8A ^ 32'h686A5727));
`else
    chk("twice_second", 64'(bus.data_out_c), 64'h00000000AB665719);
`endif
    step();
    drive(0, 0, '0, 0, 0);

    // Fill to capacity with six offered words, then drain in order.
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 32'hA0000000 + 32'(i), i, 0);
      step();
    end
    chk("full_fill", 64'(bus.fill_level_c), 64'd4);
    chk("full_ready", 64'(bus.ready_p), 64'd0);
    drive(1, 0, 32'hA0000005, 5, 1);
    for (int i = 0; i < 3; i++) step();
    drive(0, 0, '0, 0, 1);
    for (int i = 0; i < 8; i++) step();
    chk("drained_fill", 64'(bus.fill_level_c), 64'd0);

    // Continuous accept and pop at the full boundary, across pointer wrap.
    drive(1, 0, 32'h5A5A0000, 3, 0);
    for (int i = 0; i < 4; i++) step();
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 32'h5A5A0100 + 32'(i), i, 1);
      step();
      if (i >= 2) chk("steady_fill", 64'(bus.fill_level_c), 64'd3);
    end
    drive(0, 0, '0, 0, 1);
    for (int i = 0; i < 8; i++) step();

    // Asynchronous reset with three words buffered.
    drive(1, 1, 32'hDEADBEEF, 0, 0);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 32'hC0DE0000 + 32'(i), i, 0);
      step();
    end
    drive(0, 0, '0, 0, 0);
    step();
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs();
    #2;
    reset = 1'b1;
    drive(1, 0, 32'h13572468, 9, 0);
    step();
    drive(0, 0, '0, 0, 0);
    step();
    chk("post_reset_plain", 64'(bus.data_out_c), 64'h0000000013572468);
    drive(0, 0, '0, 0, 1);
    step();

    // Randomized traffic including key loads mid-flight and pops while empty.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0), $urandom(),
            int'($urandom_range(0, W - 1)), ($urandom_range(0, 2) != 0));
      step();
    end
    drive(0, 0, '0, 0, 1);
    for (int i = 0; i < 8; i++) step();
    chk("final_empty", 64'(bus.fill_level_c), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
